control_unit: RTL and testbench

- Top-level sequencer for the neural-network accelerator.
- Accepts an image/label pair on a start request and captures them.
- Drives the forward-propagation (FP) engine, the back-propagation (BP) engine and the display/draw unit through level handshakes.
- Returns to idle when the requested operation completes.

---
 rtl/cu_pkg.sv | 15 +
 rtl/cu_input_latch.sv | 36 +++
 rtl/control_unit.sv | 112 +++++++++++
 tb/tb_control_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the accelerator control unit.
//   cu_state_t : sequencer states (IDLE, FP, BP, DRAW)
//   LABEL_W    : width of the training label
package cu_pkg;

    localparam int unsigned LABEL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FP   = 2'd1,
        BP   = 2'd2,
        DRAW = 2'd3
    } cu_state_t;

endpackage

// File: rtl/cu_input_latch.sv
// Captures the image word, label and run type when a run is accepted.
// Ports:
//   clk, rst   : clock, asynchronous active-low clear
//   load       : accept strobe; captures the inputs on the next rising edge
//   image_in   : image data word          -> image_out
//   label_in   : training label           -> label_out
//   train      : run type (1 = training)  -> train_reg
module cu_input_latch
    import cu_pkg::*;
#(
    parameter int unsigned IMG_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [IMG_W-1:0]   image_in,
    input  logic [LABEL_W-1:0] label_in,
    input  logic               train,
    output logic [IMG_W-1:0]   image_out,
    output logic [LABEL_W-1:0] label_out,
    output logic               train_reg
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            image_out <= '0;
            label_out <= '0;
            train_reg <= 1'b0;
        end else if (load) begin
            image_out <= image_in;
            label_out <= label_in;
            train_reg <= train;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Top-level sequencer for the neural-network accelerator.
// A start in IDLE captures image/label/train and launches FP; a training run
// then requests BP, an inference run requests the draw unit, and the
// sequencer returns to IDLE when the last engine reports done.
// Optional build macro CU_TRAIN_DRAW_EN: training runs go FP -> BP -> DRAW.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   train, start        : run request (sampled only in IDLE)
//   fp_done, bp_done    : engine completion levels
//   drawn               : draw unit completion level
//   label_in, image_in  : data captured at start
//   do_fp, do_bp, draw  : Moore request outputs decoded from the state
//   label_out, image_out: captured data, held until the next accepted start
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned IMG_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               train,
    input  logic               start,
    input  logic               fp_done,
    input  logic               bp_done,
    input  logic               drawn,
    input  logic [LABEL_W-1:0] label_in,
    input  logic [IMG_W-1:0]   image_in,
    output logic               do_fp,
    output logic               do_bp,
    output logic               draw,
    output logic [LABEL_W-1:0] label_out,
    output logic [IMG_W-1:0]   image_out
);

    cu_state_t cs, ns;
    logic      accept;
    logic      train_reg;
    logic      started, started_d;

    assign accept = (cs == IDLE) && start;

    cu_input_latch #(
        .IMG_W (IMG_W)
    ) u_input_latch (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .image_in  (image_in),
        .label_in  (label_in),
        .train     (train),
        .image_out (image_out),
        .label_out (label_out),
        .train_reg (train_reg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs      <= IDLE;
            started <= 1'b0;
        end else begin
            cs      <= ns;
            started <= started_d;
        end
    end

    // Each state looks only at its own done input, so a done level held
    // across a transition is never consumed twice.
    always_comb begin
        ns        = cs;
        started_d = started;
        unique case (cs)
            IDLE: begin
                if (start) begin
                    ns        = FP;
                    started_d = 1'b1;
                end
            end
            FP: begin
                if (fp_done) begin
                    ns = train_reg ? BP : DRAW;
                end
            end
            BP: begin
                if (bp_done) begin
`ifdef CU_TRAIN_DRAW_EN
                    ns = DRAW;
`else
                    ns        = IDLE;
                    started_d = 1'b0;
`endif
                end
            end
            DRAW: begin
                if (drawn) begin
                    ns        = IDLE;
                    started_d = 1'b0;
                end
            end
            default: ns = IDLE;
        endcase
    end

    assign do_fp = (cs == FP);
    assign do_bp = (cs == BP);
    assign draw  = (cs == DRAW);

    // started mirrors "a run is in progress"; it must never disagree with cs.
    started_matches_state: assert property (
        @(posedge clk) disable iff (!rst) started == (cs != IDLE)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;
    import cu_pkg::*;

    localparam int unsigned IMG_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               train, start, fp_done, bp_done, drawn;
    logic [LABEL_W-1:0] label_in;
    logic [IMG_W-1:0]   image_in;
    logic               do_fp, do_bp, draw;
    logic [LABEL_W-1:0] label_out;
    logic [IMG_W-1:0]   image_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_unit #(
        .IMG_W (IMG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .train     (train),
        .start     (start),
        .fp_done   (fp_done),
        .bp_done   (bp_done),
        .drawn     (drawn),
        .label_in  (label_in),
        .image_in  (image_in),
        .do_fp     (do_fp),
        .do_bp     (do_bp),
        .draw      (draw),
        .label_out (label_out),
        .image_out (image_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request outputs packed as {do_fp, do_bp, draw}.
    task automatic check_req(input string tag, input logic [2:0] exp);
        check_eq(tag, {29'd0, do_fp, do_bp, draw}, {29'd0, exp});
    endtask

    initial begin
        rst = 1'b0; train = 1'b0; start = 1'b0;
        fp_done = 1'b0; bp_done = 1'b0; drawn = 1'b0;
        label_in = '0; image_in = '0;

        // Reset
        #12;
        check_req("reset_req_low", 3'b000);
        rst = 1'b1;
        tick();
        check_req("reset_req", 3'b000);
        check_eq("reset_cs", 32'(dut.cs), 32'(IDLE));
        check_eq("reset_label", 32'(label_out), 32'd0);
        check_eq("reset_image", image_out, 32'd0);
        tick();
        check_req("idle_hold", 3'b000);

        // Inference run
        label_in = 8'd4; image_in = 32'hdeadbeef; train = 1'b0; start = 1'b1;
        tick();
        check_req("inf_fp", 3'b100);
        check_eq("inf_label", 32'(label_out), 32'd4);
        check_eq("inf_image", image_out, 32'hdeadbeef);
        start = 1'b0;

        // Busy ignore
        image_in = 32'h12345678; label_in = 8'd7; train = 1'b1; start = 1'b1;
        tick();
        check_req("busy_fp", 3'b100);
        check_eq("busy_image", image_out, 32'hdeadbeef);
        check_eq("busy_label", 32'(label_out), 32'd4);
        start = 1'b0; train = 1'b0;

        // Spurious dones in FP
        bp_done = 1'b1; drawn = 1'b1;
        tick();
        check_req("spurious_fp", 3'b100);
        bp_done = 1'b0; drawn = 1'b0;

        fp_done = 1'b1;
        tick();
        check_req("inf_draw", 3'b001);
        fp_done = 1'b0;
        tick();
        check_req("inf_draw_hold", 3'b001);
        drawn = 1'b1;
        tick();
        check_req("inf_idle", 3'b000);
        check_eq("inf_idle_cs", 32'(dut.cs), 32'(IDLE));
        check_eq("inf_label_kept", 32'(label_out), 32'd4);
        drawn = 1'b0;

        // Training run
        label_in = 8'd9; image_in = 32'hcafef00d; train = 1'b1; start = 1'b1;
        tick();
        check_req("trn_fp", 3'b100);
        check_eq("trn_label", 32'(label_out), 32'd9);
        check_eq("trn_image", image_out, 32'hcafef00d);
        start = 1'b0; train = 1'b0;
        fp_done = 1'b1;
        tick();
        check_req("trn_bp", 3'b010);
        // fp_done held high must not disturb BP
        tick();
        check_req("trn_bp_hold", 3'b010);
        fp_done = 1'b0; bp_done = 1'b1;
        tick();
        bp_done = 1'b0;
`ifdef CU_TRAIN_DRAW_EN
        check_req("trn_draw", 3'b001);
        drawn = 1'b1;
        tick();
        drawn = 1'b0;
`endif
        check_req("trn_idle", 3'b000);
        check_eq("trn_idle_cs", 32'(dut.cs), 32'(IDLE));

        // start held across the return to IDLE relaunches with fresh inputs
        label_in = 8'd1; image_in = 32'h00000001; train = 1'b0; start = 1'b1;
        tick();
        check_req("rel_fp", 3'b100);
        label_in = 8'd2; image_in = 32'h00000002;
        fp_done = 1'b1;
        tick();
        fp_done = 1'b0;
        check_req("rel_draw", 3'b001);
        drawn = 1'b1;
        tick();
        drawn = 1'b0;
        check_req("rel_idle", 3'b000);
        check_eq("rel_label_old", 32'(label_out), 32'd1);
        tick();
        check_req("rel_fp2", 3'b100);
        check_eq("rel_label_new", 32'(label_out), 32'd2);
        check_eq("rel_image_new", image_out, 32'h00000002);
        start = 1'b0;
        fp_done = 1'b1;
        tick();
        fp_done = 1'b0;
        drawn = 1'b1;
        tick();
        drawn = 1'b0;
        check_req("rel_done", 3'b000);

        // Mid-run reset while in BP
        label_in = 8'h55; image_in = 32'ha5a5a5a5; train = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; train = 1'b0;
        fp_done = 1'b1;
        tick();
        fp_done = 1'b0;
        check_req("mid_bp", 3'b010);
        #2;
        rst = 1'b0;
        #1;
        check_req("mid_rst_req", 3'b000);
        check_eq("mid_rst_cs", 32'(dut.cs), 32'(IDLE));
        check_eq("mid_rst_label", 32'(label_out), 32'd0);
        check_eq("mid_rst_image", image_out, 32'd0);
        #4;
        rst = 1'b1;
        tick();
        check_req("post_rst_idle", 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
